// File: rtl/red_unit.sv
// Lane-reduction unit: sums all LANE_W-bit lanes of A and B, one lane pair per cycle.
// Latency LANES cycles from accept to out_valid; out_valid/Out hold while out_ready is low.
module red_unit #(
   parameter int DATA_W = 16,
   parameter int LANE_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              signed_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] Out
);

   localparam int LANES = DATA_W / LANE_W;
   localparam int ACC_W = LANE_W + $clog2(2 * LANES);
   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

   if (DATA_W % LANE_W != 0) begin : g_bad_split
      $error("red_unit: DATA_W must be a multiple of LANE_W");
   end
   if (LANES < 2) begin : g_bad_lanes
      $error("red_unit: need at least two lanes");
   end
   if (ACC_W > DATA_W) begin : g_bad_acc
      $error("red_unit: accumulator wider than DATA_W");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              sm_q, sm_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] out_q, out_d;

   logic [LANE_W-1:0] lane_a, lane_b;
   logic [ACC_W-1:0]  sum;
   logic [DATA_W-1:0] sum_ext;

   function automatic logic [ACC_W-1:0] ext_lane(input logic [LANE_W-1:0] l, input logic s);
      ext_lane = {{(ACC_W - LANE_W){s & l[LANE_W-1]}}, l};
   endfunction

   // Lane mux over the captured operands; constant part-selects only.
   always_comb begin
      lane_a = '0;
      lane_b = '0;
      for (int i = 0; i < LANES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            lane_a = a_q[i*LANE_W +: LANE_W];
            lane_b = b_q[i*LANE_W +: LANE_W];
         end
      end
   end

   assign sum = acc_q + ext_lane(lane_a, sm_q) + ext_lane(lane_b, sm_q);

   always_comb begin
      sum_ext = '0;
      sum_ext[ACC_W-1:0] = sum;
      for (int k = ACC_W; k < DATA_W; k++) begin
         sum_ext[k] = sm_q & sum[ACC_W-1];
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sm_d    = sm_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      out_d   = out_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               sm_d    = signed_mode;
               acc_d   = '0;
               idx_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d = sum;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               out_d   = sum_ext;
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sm_q    <= 1'b0;
         acc_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sm_q    <= sm_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
      end
   end

   // Handshake outputs decode registered state only.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign Out       = out_q;

endmodule

// File: doc/red_unit.md
# red_unit

Parametrised, multi-cycle lane-reduction unit for the execute stage.
- Splits two DATA_W-bit operands into LANES lanes of LANE_W bits and adds all 2×LANES lanes into one sum, one lane pair per cycle.
- Returns the sum sign- or zero-extended to DATA_W.
- Sits beside the ALU behind a valid/ready handshake, so the pipeline can stall on it.

## Interface
Parameters:
- DATA_W, 16: operand and result width.
- LANE_W, 4: lane width.
  - DATA_W % LANE_W must be 0; LANES = DATA_W/LANE_W ≥ 2.
  - ACC_W = LANE_W + clog2(2×LANES) must be ≤ DATA_W. Elaboration error otherwise.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- A  in  DATA_W  operand A.
- B  in  DATA_W  operand B.
- signed_mode  in  1  1: lanes two's complement; 0: lanes unsigned.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- Out  out  DATA_W  reduction result; held stable while out_valid=1.

## Operation
- Each lane is extended to ACC_W bits: sign-extended if the captured signed_mode=1, zero-extended otherwise.
- Sum S = Σ over i=0..LANES-1 of ext(A lane i) + ext(B lane i).
  - Lane i occupies bits [i×LANE_W +: LANE_W].
  - Computed in ACC_W bits; cannot overflow by construction.
- Out = S extended to DATA_W: sign extension if signed_mode, zero extension otherwise.
- FSM states:
  - IDLE: in_ready=1. If in_valid, capture A, B and signed_mode into internal registers, clear acc, set idx=0, go to BUSY.
  - BUSY: each cycle acc ← acc + ext(A lane idx) + ext(B lane idx) and idx ← idx+1. When idx = LANES-1, load the extended final sum into the Out register and go to DONE.
  - DONE: out_valid=1. If out_ready, go to IDLE. Otherwise hold Out and stay.
- Inputs A, B and signed_mode are ignored outside the IDLE capture cycle. Changing them mid-operation has no effect.
- in_valid in BUSY or DONE is not accepted. The requester must hold its request until in_ready.
- Reset (any state, including mid-BUSY or DONE):
  - state=IDLE, acc=0, idx=0, Out=0, out_valid=0, in_ready=1 from the cycle after the reset edge.
  - The in-flight request is discarded with no out_valid pulse.
  - rst has priority over a simultaneous in_valid or out_ready.

## Timing
- Request accepted at edge E0, i.e. the cycle with in_valid=1 and in_ready=1.
- BUSY occupies edges E1..E_LANES. out_valid=1 in the cycle after edge E_LANES.
  - Latency is LANES cycles from accept to out_valid; 4 cycles at the defaults.
- Result is consumed at the edge where out_valid=1 and out_ready=1. in_ready=1 in the next cycle.
- Minimum request spacing is LANES+2 cycles.
- out_ready held high: out_valid lasts exactly one cycle.
- out_ready low: out_valid and Out hold indefinitely.
- in_ready and out_valid are decoded from registered state only, with no combinational input→output paths.

## Test plan
All scenarios use the default parameters.
- Reset: assert rst for 2 cycles mid-BUSY → next cycle out_valid=0, in_ready=1, Out=0x0000. No result appears afterwards.
- Unsigned max: A=0xFFFF, B=0xFFFF, signed_mode=0, out_ready=1.
  - out_valid rises exactly 4 cycles after accept.
  - Out=0x0078 (120).
- Signed extremes:
  - A=B=0xFFFF, signed_mode=1 → Out=0xFFF8 (−8).
  - A=B=0x8888 → Out=0xFFC0 (−64).
  - A=B=0x7777 → Out=0x0038 (56).
- Mixed lanes, unsigned: A=0x1234, B=0x0001 → Out=0x000B.
  - Same operands with signed_mode=1 → Out=0x000B.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid → Out stable, in_ready=0, and a new in_valid is not accepted.
  - Raise out_ready → out_valid drops next cycle and in_ready=1.
- Input isolation and back-to-back:
  - Change A, B and signed_mode every cycle during BUSY → result matches the captured values.
  - Second request presented immediately after consume → accepted on the first cycle in_ready=1. Both results correct and in order.
